// File: rtl/ace_pkg.sv
// Shared types for the ACE write responder: burst/response encodings, FSM state,
// and fixed AXI field widths.
package ace_pkg;

   localparam int unsigned LEN_W  = 8;
   localparam int unsigned SIZE_W = 3;

   typedef enum logic [1:0] {
      BurstFixed = 2'b00,
      BurstIncr  = 2'b01,
      BurstWrap  = 2'b10,
      BurstRsvd  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      RespOkay   = 2'b00,
      RespExokay = 2'b01,
      RespSlverr = 2'b10,
      RespDecerr = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StResp
   } state_e;

endpackage

// File: rtl/ace_aw_fifo.sv
// Generic synchronous FIFO; push when full and pop when empty are ignored.
module ace_aw_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [PtrW:0]    cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/ace_write_responder.sv
// ACE write-channel slave: queues AW requests, forwards W beats to a backing store,
// returns one B per burst and tracks outstanding WACKs.
module ace_write_responder
   import ace_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ID_W     = 4,
   parameter int unsigned AW_DEPTH = 4,
   parameter bit          EXCL_EN  = 1'b0,
   localparam int unsigned STRB_W  = DATA_W / 8,
   localparam int unsigned PEND_W  = $clog2(AW_DEPTH + 1) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ID_W-1:0]   awid,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [7:0]        awlen,
   input  logic [2:0]        awsize,
   input  logic [1:0]        awburst,
   input  logic              awlock,
   input  logic [2:0]        awsnoop,
   input  logic [1:0]        awdomain,
   input  logic [1:0]        awbar,
   input  logic              awunique,
   input  logic              awvalid,
   output logic              awready,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [ID_W-1:0]   bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic              wack,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   output logic [PEND_W-1:0] wack_pending,
   output logic              proto_err
);

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [SIZE_W-1:0] size;
      burst_e            burst;
      logic              lock;
      logic              bar;
   } aw_entry_t;

   localparam int unsigned EntryW = $bits(aw_entry_t);
   localparam logic [PEND_W-1:0] PendMax = '1;

   aw_entry_t aw_in, head;
   logic      fifo_full, fifo_empty, pop;
   logic      unused_attr;

   // Snoop/domain/unique and the barrier type bit do not affect a plain slave.
   assign unused_attr = ^{awsnoop, awdomain, awbar[1], awunique};

   assign aw_in = '{id: awid, addr: awaddr, len: awlen, size: awsize,
                    burst: burst_e'(awburst), lock: awlock, bar: awbar[0]};

   state_e            state_q;
   logic [ID_W-1:0]   cur_id_q;
   logic [ADDR_W-1:0] cur_addr_q;
   logic [LEN_W-1:0]  cur_len_q, beat_cnt_q;
   logic [SIZE_W-1:0] cur_size_q;
   burst_e            cur_burst_q;
   logic              cur_lock_q, err_q;

   ace_aw_fifo #(
      .WIDTH (EntryW),
      .DEPTH (AW_DEPTH)
   ) u_aw_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (awvalid),
      .wdata_i (aw_in),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   logic w_hs, b_hs, last_beat;

   assign awready   = !fifo_full;
   assign pop       = (state_q == StIdle) && !fifo_empty;
   assign wready    = (state_q == StData);
   assign bvalid    = (state_q == StResp);
   assign w_hs      = wready && wvalid;
   assign b_hs      = bvalid && bready;
   assign last_beat = (beat_cnt_q == cur_len_q);

   assign bid       = cur_id_q;
   assign mem_we    = w_hs;
   assign mem_addr  = cur_addr_q;
   assign mem_wdata = w_hs ? wdata : '0;
   assign mem_wstrb = w_hs ? wstrb : '0;

   always_comb begin
      bresp = RespOkay;
      if (err_q)                      bresp = RespSlverr;
      else if (cur_lock_q && EXCL_EN) bresp = RespExokay;
   end

   logic [ADDR_W-1:0] step, bound, next_incr, next_addr;

   // WRAP keeps the upper bits of the aligned base and lets the low bits roll over.
   always_comb begin
      step      = ADDR_W'(1) << cur_size_q;
      bound     = ADDR_W'({1'b0, cur_len_q} + 9'd1) << cur_size_q;
      next_incr = cur_addr_q + step;
      case (cur_burst_q)
         BurstFixed: next_addr = cur_addr_q;
         BurstWrap:  next_addr = (cur_addr_q & ~(bound - 1'b1)) | (next_incr & (bound - 1'b1));
         default:    next_addr = next_incr;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cur_id_q    <= '0;
         cur_addr_q  <= '0;
         cur_len_q   <= '0;
         cur_size_q  <= '0;
         cur_burst_q <= BurstFixed;
         cur_lock_q  <= 1'b0;
         beat_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (!fifo_empty) begin
                  cur_id_q    <= head.id;
                  cur_addr_q  <= head.addr;
                  cur_len_q   <= head.len;
                  cur_size_q  <= head.size;
                  cur_burst_q <= head.burst;
                  cur_lock_q  <= head.lock && !head.bar;
                  beat_cnt_q  <= '0;
                  err_q       <= 1'b0;
                  state_q     <= head.bar ? StResp : StData;
               end
            end
            StData: begin
               if (wvalid) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
                  cur_addr_q <= next_addr;
                  if ((wlast != last_beat) || (cur_burst_q == BurstRsvd)) err_q <= 1'b1;
                  if (last_beat) state_q <= StResp;
               end
            end
            StResp: begin
               if (bready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wack_pending <= '0;
         proto_err    <= 1'b0;
      end else if (b_hs && !wack) begin
         if (wack_pending == PendMax) proto_err <= 1'b1;
         else                         wack_pending <= wack_pending + 1'b1;
      end else if (wack && !b_hs) begin
         if (wack_pending == '0) proto_err <= 1'b1;
         else                    wack_pending <= wack_pending - 1'b1;
      end
   end

endmodule

// File: tb/tb_ace_write_responder.sv
// Scoreboard bench for ace_write_responder: expected beats and responses are queued
// as stimulus is driven and compared as the DUT emits them.
module tb_ace_write_responder;

   localparam int unsigned AW_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awlock;
   logic [2:0]  awsnoop;
   logic [1:0]  awdomain;
   logic [1:0]  awbar;
   logic        awunique;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic        wack;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [3:0]  wack_pending;
   logic        proto_err;

   always #5 clk = ~clk;

   ace_write_responder #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .ID_W     (4),
      .AW_DEPTH (AW_DEPTH),
      .EXCL_EN  (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .awid         (awid),
      .awaddr       (awaddr),
      .awlen        (awlen),
      .awsize       (awsize),
      .awburst      (awburst),
      .awlock       (awlock),
      .awsnoop      (awsnoop),
      .awdomain     (awdomain),
      .awbar        (awbar),
      .awunique     (awunique),
      .awvalid      (awvalid),
      .awready      (awready),
      .wdata        (wdata),
      .wstrb        (wstrb),
      .wlast        (wlast),
      .wvalid       (wvalid),
      .wready       (wready),
      .bid          (bid),
      .bresp        (bresp),
      .bvalid       (bvalid),
      .bready       (bready),
      .wack         (wack),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .wack_pending (wack_pending),
      .proto_err    (proto_err)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } mem_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_t;

   mem_t exp_mem[$];
   b_t   exp_b[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   exp_pend = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we) begin
            check_eq("mem_expected", exp_mem.size() > 0, 1);
            if (exp_mem.size() > 0) begin
               mem_t m;
               m = exp_mem.pop_front();
               check_eq("mem_addr", mem_addr, m.addr);
               check_eq("mem_wdata", mem_wdata, m.data);
               check_eq("mem_wstrb", mem_wstrb, m.strb);
            end
         end
         if (bvalid && bready) begin
            check_eq("b_expected", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) begin
               b_t b;
               b = exp_b.pop_front();
               check_eq("bid", bid, b.id);
               check_eq("bresp", bresp, b.resp);
            end
            exp_pend++;
         end
      end
   end

   // All driving tasks start and end just after a rising edge.
   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic lock, input logic [1:0] bar);
      int n = 0;
      awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst;
      awlock = lock; awbar = bar; awvalid = 1'b1;
      @(negedge clk);
      while (!awready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check_eq("aw_timeout", awready, 1);
      @(posedge clk);
      #1 awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n = 0;
      wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
      @(negedge clk);
      while (!wready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check_eq("w_timeout", wready, 1);
      @(posedge clk);
      #1 wvalid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_b.size() > 0 || exp_mem.size() > 0) && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_eq("drain", n < 500, 1);
   endtask

   task automatic pulse_wack();
      wack = 1'b1;
      @(posedge clk);
      #1 wack = 1'b0;
   endtask

   task automatic push_aw_until_full(output int acc);
      acc = 0;
      for (int c = 0; c < 30 && acc < AW_DEPTH + 2; c++) begin
         logic rdy;
         awid = 4'(10 + acc); awaddr = 32'h200 + 32'(4 * acc); awlen = 8'd0;
         awsize = 3'd2; awburst = 2'b01; awlock = 1'b0; awbar = 2'b00; awvalid = 1'b1;
         @(negedge clk);
         rdy = awready;
         @(posedge clk);
         #1;
         if (rdy) begin
            exp_mem.push_back('{addr: 32'h200 + 32'(4 * acc), data: 32'hB0 + 32'(acc),
                                strb: 4'hF});
            exp_b.push_back('{id: 4'(10 + acc), resp: 2'b00});
            acc++;
         end
      end
      awvalid = 1'b0;
   endtask

   initial begin
      int acc;
      logic [31:0] wrap_addr [4];
      logic [1:0]  early_last [4];

      rst_n = 1'b0; awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0;
      awburst = '0; awlock = 1'b0; awsnoop = '0; awdomain = '0; awbar = '0; awunique = 1'b0;
      wvalid = 1'b0; wdata = '1; wstrb = '1; wlast = 1'b0; bready = 1'b1; wack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_awready", awready, 1);
      check_eq("rst_wready", wready, 0);
      check_eq("rst_bvalid", bvalid, 0);
      check_eq("rst_bid", bid, 0);
      check_eq("rst_bresp", bresp, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_mem_wstrb", mem_wstrb, 0);
      check_eq("rst_wack_pending", wack_pending, 0);
      check_eq("rst_proto_err", proto_err, 0);
      rst_n = 1'b1; wdata = '0; wstrb = '0;
      @(posedge clk);
      #1;

      // WACK accounting using barrier bursts
      for (int i = 0; i < 3; i++) begin
         exp_b.push_back('{id: 4'(i), resp: 2'b00});
         send_aw(4'(i), 32'h0, 8'd0, 2'b01, 1'b0, 2'b01);
         wait_drain();
         check_eq("wack_pending_up", wack_pending, 64'(i + 1));
      end
      for (int i = 0; i < 3; i++) begin
         pulse_wack();
         check_eq("wack_pending_down", wack_pending, 64'(2 - i));
      end
      check_eq("proto_err_before", proto_err, 0);
      pulse_wack();
      check_eq("wack_underflow_cnt", wack_pending, 0);
      check_eq("wack_underflow_err", proto_err, 1);
      repeat (3) @(posedge clk);
      #1;
      check_eq("proto_err_sticky", proto_err, 1);
      rst_n = 1'b0;
      #1;
      check_eq("proto_err_reset", proto_err, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_pend = 0;
      @(posedge clk);
      #1;

      // INCR burst with latency checks
      for (int i = 0; i < 4; i++)
         exp_mem.push_back('{addr: 32'h100 + 32'(4 * i), data: 32'h1000 + 32'(i),
                             strb: (i == 2) ? 4'h3 : 4'hF});
      exp_b.push_back('{id: 4'h5, resp: 2'b00});
      send_aw(4'h5, 32'h100, 8'd3, 2'b01, 1'b0, 2'b00);
      check_eq("wready_not_yet", wready, 0);
      @(posedge clk);
      #1;
      check_eq("aw_to_wready", wready, 1);
      for (int i = 0; i < 4; i++)
         send_w(32'h1000 + 32'(i), (i == 2) ? 4'h3 : 4'hF, i == 3);
      check_eq("last_to_bvalid", bvalid, 1);
      wait_drain();

      // WRAP burst
      wrap_addr[0] = 32'h108; wrap_addr[1] = 32'h10C; wrap_addr[2] = 32'h100;
      wrap_addr[3] = 32'h104;
      for (int i = 0; i < 4; i++)
         exp_mem.push_back('{addr: wrap_addr[i], data: 32'h2000 + 32'(i), strb: 4'hF});
      exp_b.push_back('{id: 4'h6, resp: 2'b00});
      send_aw(4'h6, 32'h108, 8'd3, 2'b10, 1'b0, 2'b00);
      for (int i = 0; i < 4; i++) send_w(32'h2000 + 32'(i), 4'hF, i == 3);
      wait_drain();

      // Early wlast: all four beats still written, response SLVERR
      early_last[0] = 2'd0; early_last[1] = 2'd1; early_last[2] = 2'd0; early_last[3] = 2'd1;
      for (int i = 0; i < 4; i++)
         exp_mem.push_back('{addr: 32'h300 + 32'(4 * i), data: 32'h3000 + 32'(i), strb: 4'hF});
      exp_b.push_back('{id: 4'h7, resp: 2'b10});
      send_aw(4'h7, 32'h300, 8'd3, 2'b01, 1'b0, 2'b00);
      for (int i = 0; i < 4; i++) send_w(32'h3000 + 32'(i), 4'hF, early_last[i][0]);
      wait_drain();

      // Exclusive write with exclusives enabled
      exp_mem.push_back('{addr: 32'h400, data: 32'h4444, strb: 4'hF});
      exp_b.push_back('{id: 4'h8, resp: 2'b01});
      send_aw(4'h8, 32'h400, 8'd0, 2'b01, 1'b1, 2'b00);
      send_w(32'h4444, 4'hF, 1'b1);
      wait_drain();

      // Barrier: no data phase, B one cycle after the pop
      exp_b.push_back('{id: 4'h9, resp: 2'b00});
      send_aw(4'h9, 32'h500, 8'd0, 2'b01, 1'b0, 2'b01);
      @(posedge clk);
      #1;
      check_eq("barrier_bvalid", bvalid, 1);
      check_eq("barrier_wready", wready, 0);
      wait_drain();

      // Back-pressure: first burst completes but its B is held, queue fills behind it
      bready = 1'b0;
      fork
         push_aw_until_full(acc);
         send_w(32'hB0, 4'hF, 1'b1);
      join
      check_eq("bp_accepts", acc, AW_DEPTH + 1);
      check_eq("bp_awready", awready, 0);
      check_eq("bp_bvalid_held", bvalid, 1);
      bready = 1'b1;
      for (int i = 1; i <= AW_DEPTH; i++) send_w(32'hB0 + 32'(i), 4'hF, 1'b1);
      wait_drain();
      check_eq("bp_awready_after", awready, 1);

      check_eq("final_wack_pending", wack_pending, 64'(exp_pend));
      check_eq("final_proto_err", proto_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
